ahb_bram_ctrl: RTL and testbench

- AHB-Lite slave front end for the on-chip code/data block RAM in the Cortex-M0 SoC; sits between the bus matrix slave port and the dual-port BRAM (write port A, read port B).
- Translates AHB address/data phases into the BRAM's port-A byte-write and port-B word-read with zero wait states.
- Forwards pending write data into back-to-back reads of the same word, because the BRAM returns pre-write (read-first) data.

---
 rtl/ahb_bram_ctrl.sv | 100 ++++++++++
 tb/tb_ahb_bram_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite zero-wait-state slave for a read-first dual-port BRAM.
// Writes go through port A one cycle after acceptance; reads go through port B with same-word forwarding.
module ahb_bram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDRA,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDRB,
  input  logic [31:0]           BRAM_RDATA
);

  logic                  acc;
  logic [ADDR_WIDTH-1:0] haddr_word;
  logic [3:0]            strb;

  logic                  wr_pend_q,  wr_pend_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
  logic [3:0]            wr_strb_q,  wr_strb_d;
  logic                  fwd_hit_q,  fwd_hit_d;
  logic [3:0]            fwd_strb_q, fwd_strb_d;
  logic [31:0]           fwd_data_q, fwd_data_d;

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign acc        = HSEL & HREADY & HTRANS[1];
  assign haddr_word = HADDR[ADDR_WIDTH+1:2];

  always_comb begin
    case (HSIZE)
      3'd0:    strb = 4'b0001 << HADDR[1:0];
      3'd1:    strb = HADDR[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  always_comb begin
    wr_pend_d  = acc & HWRITE;
    wr_addr_d  = wr_addr_q;
    wr_strb_d  = wr_strb_q;
    if (wr_pend_d) begin
      wr_addr_d = haddr_word;
      wr_strb_d = strb;
    end
    // BRAM is read-first: a read landing on the word being written this cycle sees stale data.
    fwd_hit_d  = acc & ~HWRITE & wr_pend_q & (haddr_word == wr_addr_q);
    fwd_strb_d = fwd_strb_q;
    fwd_data_d = fwd_data_q;
    if (fwd_hit_d) begin
      fwd_strb_d = wr_strb_q;
      fwd_data_d = HWDATA;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_strb_q  <= '0;
      fwd_hit_q  <= 1'b0;
      fwd_strb_q <= '0;
      fwd_data_q <= '0;
    end else begin
      wr_pend_q  <= wr_pend_d;
      wr_addr_q  <= wr_addr_d;
      wr_strb_q  <= wr_strb_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_strb_q <= fwd_strb_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign BRAM_WE    = wr_pend_q ? wr_strb_q : 4'b0000;
  assign BRAM_ADDRA = wr_addr_q;
  assign BRAM_WDATA = HWDATA;
  assign BRAM_ADDRB = haddr_word;
  assign HREADYOUT  = 1'b1;
  assign HRESP      = 1'b0;

  always_comb begin
    HRDATA = BRAM_RDATA;
    for (int i = 0; i < 4; i++) begin
      if (fwd_hit_q && fwd_strb_q[i]) HRDATA[8*i +: 8] = fwd_data_q[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Bench for ahb_bram_ctrl: directed vector table, randomized traffic against a
// program-order memory model, and a reset-abort sequence.
module tb_ahb_bram_ctrl;

  localparam int AW     = 14;
  localparam int KRD    = 0;
  localparam int KWR    = 1;
  localparam int KIDLE  = 2;
  localparam int KNOSEL = 3;
  localparam int KNORDY = 4;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  exp_we;
    logic [31:0] exp_rd;
  } vec_t;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [AW-1:0] BRAM_ADDRA;
  logic [31:0]   BRAM_WDATA;
  logic [3:0]    BRAM_WE;
  logic [AW-1:0] BRAM_ADDRB;
  logic [31:0]   bram_rdata;

  int total = 0;
  int bad   = 0;

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HSIZE      (HSIZE),
    .HWRITE     (HWRITE),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HREADYOUT  (HREADYOUT),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA),
    .BRAM_ADDRA (BRAM_ADDRA),
    .BRAM_WDATA (BRAM_WDATA),
    .BRAM_WE    (BRAM_WE),
    .BRAM_ADDRB (BRAM_ADDRB),
    .BRAM_RDATA (bram_rdata)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] init_val(input int i);
    case (i)
      8:       return 32'h1122_3344;
      16:      return 32'h1234_5678;
      21:      return 32'h5454_5454;
      24:      return 32'h6060_6060;
      default: return i * 32'h9E37_79B9 + 32'h0000_1357;
    endcase
  endfunction

  // Read-first BRAM with one-cycle registered read; preloaded on the first edge.
  logic [31:0] bram_mem [2**AW];
  logic        mem_ready = 1'b0;
  always @(posedge HCLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2**AW; i++) bram_mem[i] <= init_val(i);
      bram_rdata <= 32'h0;
      mem_ready  <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (BRAM_WE[b]) bram_mem[BRAM_ADDRA][8*b +: 8] <= BRAM_WDATA[8*b +: 8];
      bram_rdata <= bram_mem[BRAM_ADDRB];
    end
  end

  // Reference: a plain word-addressed memory updated in bus program order.
  logic [31:0] ref_mem [2**AW];

  function automatic int word_of(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  function automatic logic [3:0] lanes(input logic [31:0] a, input logic [2:0] size);
    int n;
    int base;
    logic [3:0] m;
    if (size == 3'd0)      begin n = 1; base = int'(a[1:0]); end
    else if (size == 3'd1) begin n = 2; base = a[1] ? 2 : 0; end
    else                   begin n = 4; base = 0; end
    for (int b = 0; b < 4; b++) m[b] = (b >= base) && (b < base + n);
    return m;
  endfunction

  function automatic void model_step(input vec_t v);
    int w;
    logic [3:0] m;
    if (v.kind != KWR) return;
    w = word_of(v.addr);
    m = lanes(v.addr, v.size);
    for (int b = 0; b < 4; b++)
      if (m[b]) ref_mem[w][8*b +: 8] = v.wdata[8*b +: 8];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    HADDR  = v.addr;
    HSIZE  = v.size;
    HSEL   = 1'b1;
    HREADY = 1'b1;
    HTRANS = {1'b1, 1'($urandom_range(0, 1))};
    HWRITE = (v.kind != KRD);
    case (v.kind)
      KIDLE:   HTRANS = {1'b0, 1'($urandom_range(0, 1))};
      KNOSEL:  HSEL   = 1'b0;
      KNORDY:  HREADY = 1'b0;
      default: ;
    endcase
  endtask

  task automatic drive_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HADDR  = $urandom;
    HREADY = 1'b1;
  endtask

  // Address phase of vector i overlaps the data phase of vector i-1.
  task automatic run_vecs(input vec_t q[$]);
    vec_t prev;
    bit   have_prev;
    have_prev = 1'b0;
    for (int i = 0; i <= q.size(); i++) begin
      @(posedge HCLK); #1;
      if (have_prev && prev.kind == KWR) HWDATA = prev.wdata;
      else                               HWDATA = $urandom;
      if (i < q.size()) drive(q[i]);
      else              drive_idle();
      @(negedge HCLK);
      chk("ready_resp", 32'({HREADYOUT, HRESP}), 32'h2);
      if (have_prev) begin
        chk("we", 32'(BRAM_WE), 32'(prev.exp_we));
        if (prev.kind == KWR) begin
          chk("addra", 32'(BRAM_ADDRA), 32'(word_of(prev.addr)));
          chk("wdata", BRAM_WDATA, prev.wdata);
        end
        if (prev.kind == KRD) chk("hrdata", HRDATA, prev.exp_rd);
      end
      if (i < q.size()) begin
        prev      = q[i];
        have_prev = 1'b1;
      end
    end
  endtask

  vec_t dir_tab [17];
  vec_t vecs [$];
  vec_t tail [$];
  vec_t v;

  initial begin
    HRESETn = 1'b0;
    HSEL    = 1'b0;
    HADDR   = 32'h0;
    HTRANS  = 2'b00;
    HSIZE   = 3'd0;
    HWRITE  = 1'b0;
    HWDATA  = 32'h0;
    HREADY  = 1'b1;
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = init_val(i);

    dir_tab[0]  = '{KWR,    32'h0000_0010, 3'd2, 32'hDEAD_BEEF, 4'hF,    32'h0};
    dir_tab[1]  = '{KIDLE,  32'h0000_0010, 3'd2, 32'h0,         4'h0,    32'h0};
    dir_tab[2]  = '{KRD,    32'h0000_0010, 3'd2, 32'h0,         4'h0,    32'hDEAD_BEEF};
    dir_tab[3]  = '{KWR,    32'h0000_0021, 3'd0, 32'h0000_AA00, 4'b0010, 32'h0};
    dir_tab[4]  = '{KWR,    32'h0000_0022, 3'd0, 32'h0055_0000, 4'b0100, 32'h0};
    dir_tab[5]  = '{KRD,    32'h0000_0020, 3'd2, 32'h0,         4'h0,    32'h1155_AA44};
    dir_tab[6]  = '{KWR,    32'h0000_0030, 3'd2, 32'hCAFE_F00D, 4'hF,    32'h0};
    dir_tab[7]  = '{KRD,    32'h0000_0030, 3'd2, 32'h0,         4'h0,    32'hCAFE_F00D};
    dir_tab[8]  = '{KWR,    32'h0000_0042, 3'd1, 32'hBEEF_0000, 4'b1100, 32'h0};
    dir_tab[9]  = '{KRD,    32'h0000_0040, 3'd2, 32'h0,         4'h0,    32'hBEEF_5678};
    dir_tab[10] = '{KWR,    32'h0000_0050, 3'd2, 32'h0BAD_CAFE, 4'hF,    32'h0};
    dir_tab[11] = '{KRD,    32'h0000_0054, 3'd2, 32'h0,         4'h0,    32'h5454_5454};
    dir_tab[12] = '{KWR,    32'h0000_0071, 3'd3, 32'h0102_0304, 4'hF,    32'h0};
    dir_tab[13] = '{KRD,    32'h0000_0070, 3'd2, 32'h0,         4'h0,    32'h0102_0304};
    dir_tab[14] = '{KWR,    32'hFFFF_0074, 3'd2, 32'h7777_AAAA, 4'hF,    32'h0};
    dir_tab[15] = '{KNOSEL, 32'h0000_0074, 3'd2, 32'h0,         4'h0,    32'h0};
    dir_tab[16] = '{KRD,    32'h0000_0074, 3'd2, 32'h0,         4'h0,    32'h7777_AAAA};
    for (int i = 0; i < 17; i++) begin
      vecs.push_back(dir_tab[i]);
      model_step(dir_tab[i]);
    end

    // Random traffic over a small window so reads often hit freshly written words.
    for (int k = 0; k < 300; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4)       v.kind = KRD;
      else if (r < 8)  v.kind = KWR;
      else if (r == 8) v.kind = KIDLE;
      else             v.kind = ($urandom_range(0, 1) != 0) ? KNOSEL : KNORDY;
      if ($urandom_range(0, 15) == 0) v.addr = ($urandom & 32'hFFFF_0000) | 32'h0000_FFFC;
      else v.addr = ($urandom & 32'hFFFF_0000) | (32'h200 + 4 * $urandom_range(0, 7));
      v.addr  = v.addr | 32'($urandom_range(0, 3));
      v.size  = 3'($urandom_range(0, 3));
      v.wdata = $urandom;
      v.exp_we = (v.kind == KWR) ? lanes(v.addr, v.size) : 4'h0;
      v.exp_rd = ref_mem[word_of(v.addr)];
      model_step(v);
      vecs.push_back(v);
    end

    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_we",     32'(BRAM_WE), 32'h0);
    chk("rst_addra",  32'(BRAM_ADDRA), 32'h0);
    chk("rst_hrdata", HRDATA, bram_rdata);
    chk("rst_ready_resp", 32'({HREADYOUT, HRESP}), 32'h2);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    run_vecs(vecs);

    // Reset sampled on the edge that would accept a write to 0x60.
    @(posedge HCLK); #1;
    v = '{KWR, 32'h0000_0064, 3'd2, 32'hA5A5_A5A5, 4'hF, 32'h0};
    drive(v);
    HWDATA = $urandom;
    @(posedge HCLK); #1;
    HWDATA = 32'hA5A5_A5A5;
    v = '{KWR, 32'h0000_0060, 3'd2, 32'hFFFF_FFFF, 4'hF, 32'h0};
    drive(v);
    HRESETn = 1'b0;
    @(negedge HCLK);
    chk("rst_mid_ready_resp", 32'({HREADYOUT, HRESP}), 32'h2);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    HWDATA  = 32'hFFFF_FFFF;
    drive_idle();
    @(negedge HCLK);
    chk("we_after_rst", 32'(BRAM_WE), 32'h0);
    chk("rst_post_ready_resp", 32'({HREADYOUT, HRESP}), 32'h2);
    tail.push_back('{KRD, 32'h0000_0060, 3'd2, 32'h0, 4'h0, 32'h6060_6060});
    run_vecs(tail);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
